// File: rtl/vc_plane_input_unit.sv
// vc_plane_input_unit
// Router-side receiver for the time-multiplexed VC-plane injection channel.
// An external selector names the VC that owns the shared 32-bit channel in a
// given cycle. Accepted flits are framing-checked per VC and pushed into
// per-VC first-word-fall-through FIFOs that feed the router pipeline.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   VCPlaneSelector   VC owning the channel; values >= VC mean no owner
//   data_in/valid_in  flit from the source for the selected VC
//   ready_in          channel can take a flit on the selected VC
//   data_out          per-VC head-of-FIFO flit, VC v at [v*32 +: 32]
//   valid_out         per-VC FIFO non-empty
//   ready_out         per-VC pop request from the router
//   in_packet         per-VC framing FSM is inside a packet
//   frame_err         per-VC sticky framing-error flag
//   pkt_count         saturating count of accepted tails, all VCs
//
// Framing FSM (one per VC):
//   state  | meaning
//   IDLE   | between packets, only a head is legal
//   IN_PKT | head seen, body or tail legal
module vc_plane_input_unit #(
    parameter int VC    = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [$clog2(VC)-1:0]  VCPlaneSelector,
    input  logic [31:0]            data_in,
    input  logic                   valid_in,
    output logic                   ready_in,
    output logic [32*VC-1:0]       data_out,
    output logic [VC-1:0]          valid_out,
    input  logic [VC-1:0]          ready_out,
    output logic [VC-1:0]          in_packet,
    output logic [VC-1:0]          frame_err,
    output logic [CNT_W-1:0]       pkt_count
);

    localparam int SEL_W = $clog2(VC);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_BODY = 2'b10;
    localparam logic [1:0] FT_TAIL = 2'b11;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t         state_q [VC];
    state_t         state_d [VC];
    logic [PTR_W:0] wr_ptr  [VC];
    logic [PTR_W:0] rd_ptr  [VC];
    logic [31:0]    mem     [VC][DEPTH];

    logic [VC-1:0] full;
    logic [VC-1:0] empty;
    logic [VC-1:0] push;
    logic [VC-1:0] pop;
    logic [VC-1:0] err_set;
    logic          sel_valid;
    logic          sel_full;
    logic          xfer;
    logic          tail_done;
    logic [1:0]    flit_type;

    assign flit_type = data_in[31:30];
    assign sel_valid = {1'b0, VCPlaneSelector} < (SEL_W+1)'(VC);

    // Full/empty use the wrap bit: same index with differing wrap means full.
    // Full is taken before this cycle's pop, so a full FIFO never bypasses.
    for (genvar g = 0; g < VC; g++) begin : g_vc
        assign full[g]  = (wr_ptr[g][PTR_W-1:0] == rd_ptr[g][PTR_W-1:0]) &&
                          (wr_ptr[g][PTR_W] != rd_ptr[g][PTR_W]);
        assign empty[g] = (wr_ptr[g] == rd_ptr[g]);
        assign pop[g]   = !empty[g] && ready_out[g];
        assign valid_out[g]          = !empty[g];
        assign data_out[g*32 +: 32]  = mem[g][rd_ptr[g][PTR_W-1:0]];
        assign in_packet[g]          = (state_q[g] == IN_PKT);
    end

    always_comb begin
        sel_full = 1'b0;
        for (int v = 0; v < VC; v++) begin
            if (VCPlaneSelector == SEL_W'(v)) sel_full = full[v];
        end
    end

    assign ready_in = !rst && sel_valid && !sel_full;
    assign xfer     = valid_in && ready_in;

    // Illegal flits still complete the handshake; they are simply not stored.
    always_comb begin
        push      = '0;
        err_set   = '0;
        tail_done = 1'b0;
        for (int v = 0; v < VC; v++) begin
            state_d[v] = state_q[v];
            if (xfer && (VCPlaneSelector == SEL_W'(v))) begin
                case (state_q[v])
                    IDLE: begin
                        if (flit_type == FT_HEAD) begin
                            push[v]    = 1'b1;
                            state_d[v] = IN_PKT;
                        end else begin
                            err_set[v] = 1'b1;
                        end
                    end
                    IN_PKT: begin
                        if (flit_type == FT_BODY) begin
                            push[v] = 1'b1;
                        end else if (flit_type == FT_TAIL) begin
                            push[v]    = 1'b1;
                            state_d[v] = IDLE;
                            tail_done  = 1'b1;
                        end else begin
                            err_set[v] = 1'b1;
                        end
                    end
                    default: state_d[v] = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < VC; v++) begin
            if (rst) state_q[v] <= IDLE;
            else     state_q[v] <= state_d[v];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
            end
            frame_err <= '0;
            pkt_count <= '0;
        end else begin
            for (int v = 0; v < VC; v++) begin
                if (push[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
                if (pop[v])  rd_ptr[v] <= rd_ptr[v] + 1'b1;
            end
            frame_err <= frame_err | err_set;
            if (tail_done && (pkt_count != {CNT_W{1'b1}}))
                pkt_count <= pkt_count + 1'b1;
        end
    end

    // Storage needs no reset; emptiness is carried by the pointers.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC; v++) begin
            if (push[v]) mem[v][wr_ptr[v][PTR_W-1:0]] <= data_in;
        end
    end

endmodule

// File: doc/vc_plane_input_unit.md
Name: vc_plane_input_unit

Overview:
- Router-side receiver for the time-multiplexed VC-plane injection channel driven by a node's traffic source.
- Each cycle, an external VC-plane selector names the one VC allowed to transfer on the shared 32-bit data/valid/ready channel.
- The block demultiplexes accepted flits into per-VC FIFOs, checks packet framing per VC, and presents per-VC flit streams to the router pipeline.

Parameters:
- VC, 4, number of virtual channels; 2..8.
- DEPTH, 4, flit slots per VC FIFO; power of two, at least 2.
- CNT_W, 16, width of the accepted-packet counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- VCPlaneSelector  input  $clog2(VC)  VC owning the channel this cycle; values at or above VC mean no VC owns it.
- data_in  input  32  flit from the source.
- valid_in  input  1  flit on data_in is valid for the selected VC.
- ready_in  output  1  block can take a flit on the selected VC.
- data_out  output  32*VC  flat per-VC head-of-FIFO flit; VC v occupies bits [v*32 +: 32].
- valid_out  output  VC  per-VC FIFO non-empty.
- ready_out  input  VC  per-VC pop request from the router.
- in_packet  output  VC  per-VC framing state is IN_PKT.
- frame_err  output  VC  per-VC sticky framing-error flag.
- pkt_count  output  CNT_W  total accepted tails across all VCs.

Behaviour:
- Flit type is data_in[31:30]: 01 head, 10 body, 11 tail, 00 null. Head fields: [29:28] priority, [27:16] packet id, [15:8] source, [7:0] destination. The block carries all 32 bits unchanged.
- ready_in is combinational: selector < VC, FIFO[selector] not full, and rst low.
- Transfer occurs when valid_in and ready_in are both high at a rising edge.
- Full is computed before the current cycle's pop. A full FIFO blocks a push even if the same VC pops in that cycle; there is no bypass.
- Per-VC framing FSM with two states, IDLE and IN_PKT, reset to IDLE. Only transfers on that VC advance it.
  - IDLE + head: store the flit, go to IN_PKT.
  - IN_PKT + body: store the flit, stay in IN_PKT.
  - IN_PKT + tail: store the flit, go to IDLE, increment pkt_count.
  - Illegal cases are IDLE + body, IDLE + tail, IN_PKT + head, and any null flit. Each one is dropped (not stored), sets frame_err[v], and leaves the state unchanged.
  - A dropped flit still completes the handshake so the source never deadlocks.
- Single-flit packets are not supported; a packet is always a head followed by a tail.
- FIFO output is first-word fall-through. A flit stored at edge N appears on data_out/valid_out after edge N, giving 1-cycle latency.
- Pop occurs when valid_out[v] and ready_out[v] are both high. data_out for an empty VC is don't-care; verification checks it only while valid_out is high.
- Pointers are log2(DEPTH) bits plus a wrap bit. Full and empty come from pointer equality and the wrap bit, and pointers wrap modulo DEPTH.
- Simultaneous push and pop on the same non-full VC leaves occupancy unchanged and preserves order.
- pkt_count saturates at all-ones and never wraps.
- frame_err clears only on reset.
- Reset mid-packet: all FIFOs empty, FSMs IDLE, pkt_count 0, frame_err 0, ready_in 0 while rst is high.
  - A source resuming with body flits after reset gets those flits dropped and frame_err set, which is the intended behaviour.
- Ordering is preserved within a VC. There is no ordering relation between VCs.

Test Plan:
1. VC=4, DEPTH=4, selector cycling 0..3; packet 0x4000_0012, 0x8000_0000, 0xC000_0012 on VC1 -> the three flits appear in order on data_out[63:32] with 1-cycle latency; in_packet[1] goes 1 then 0; pkt_count=1; frame_err=0.
2. ready_out[2]=0; push 5 flits on VC2 (head, body x3, tail) -> the 5th is stalled with ready_in=0 while selector=2; raising ready_out[2] drains FIFO, the tail is then accepted, total order preserved.
3. Body 0x8000_0000 on VC3 while IDLE -> handshake completes, nothing appears on valid_out[3], frame_err[3]=1, in_packet[3]=0; a following legal packet on VC3 is delivered intact.
4. Head on VC0, then a second head 0x5001_0000 on VC0 before any tail -> second head is dropped, frame_err[0]=1, in_packet[0] stays 1; the subsequent tail closes the packet and pkt_count increments by 1.
5. Interleaved packets on VC1 and VC2 with simultaneous push/pop every cycle -> each VC's stream is in order, no flit lost, occupancy never exceeds 4.
6. Assert rst for one cycle with 2 flits buffered on VC1 mid-packet -> next cycle valid_out=0, in_packet=0, pkt_count=0, frame_err=0; ready_in was 0 during the reset cycle.
